uart_bus_fsm: RTL and testbench

- Parametrised bus-side access sequencer for the UART peripheral; successor to the fixed 3-bit-address UART FSM.
- Accepts single-cycle rd_en/wr_en requests from the bus adapter and sequences register-bank and PHY FIFO strobes, then returns ack.
- Adds a latched address, configurable data-register offsets and a generic address width.
- Adds FIFO back-pressure: a TX write waits while the TX FIFO is full, and an RX read waits while the RX FIFO is empty, bounded by an optional timeout that reports an error.

---
 rtl/uart_bus_fsm.sv | 130 +++++++++++++
 tb/tb_uart_bus_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_bus_fsm.sv
// Bus-side access sequencer for the UART: register-bank strobes, FIFO push/pop, ack.
// Optional Wait timeout enabled by defining UART_BUS_FSM_TIMEOUT_EN.
module uart_bus_fsm #(
  parameter int ADDR_WIDTH     = 3,
  parameter int TXDATA_ADDR    = 0,
  parameter int RXDATA_ADDR    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  tx_fifo_full,
  input  logic                  rx_fifo_empty,
  output logic                  op,
  output logic                  ack,
  output logic                  err,
  output logic                  bank_rd_en,
  output logic                  bank_wr_en,
  output logic                  rxdata_wr_en,
  output logic                  tx_fifo_wr_en,
  output logic                  rx_fifo_rd_en,
  output logic [2:0]            present_state_db
);

  localparam logic [ADDR_WIDTH-1:0] TX_A = ADDR_WIDTH'(TXDATA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] RX_A = ADDR_WIDTH'(RXDATA_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_WAIT  = 3'd3,
    S_ENDOP = 3'd4,
    S_FINAL = 3'd5
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    dir_q;      // 1 = write access
  logic                    blocked;
  logic                    abort;

`ifdef UART_BUS_FSM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign blocked = dir_q ? tx_fifo_full : rx_fifo_empty;

  always_comb begin
    next_state = S_IDLE;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_en)      next_state = S_READ;
        else if (wr_en) next_state = S_WRITE;
        else            next_state = S_IDLE;
      end
      S_READ: begin
        if (addr_q != RX_A)    next_state = S_FINAL;
        else if (rx_fifo_empty) next_state = S_WAIT;
        else                   next_state = S_ENDOP;
      end
      S_WRITE: begin
        if (addr_q != TX_A)   next_state = S_FINAL;
        else if (tx_fifo_full) next_state = S_WAIT;
        else                  next_state = S_ENDOP;
      end
      S_WAIT: begin
        // A condition that clears on the expiry cycle still completes normally.
        if (!blocked) next_state = S_ENDOP;
`ifdef UART_BUS_FSM_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          next_state = S_FINAL;
          abort      = 1'b1;
        end
`endif
        else next_state = S_WAIT;
      end
      S_ENDOP: next_state = S_FINAL;
      S_FINAL: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      dir_q         <= 1'b0;
      op            <= 1'b0;
      ack           <= 1'b0;
      err           <= 1'b0;
      bank_rd_en    <= 1'b0;
      bank_wr_en    <= 1'b0;
      rxdata_wr_en  <= 1'b0;
      tx_fifo_wr_en <= 1'b0;
      rx_fifo_rd_en <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && (rd_en || wr_en)) begin
        addr_q <= addr;
        dir_q  <= ~rd_en;
      end
      // Outputs decode next_state so they line up with the state they describe.
      op            <= (next_state == S_READ) || (next_state == S_WRITE) ||
                       (next_state == S_WAIT) || (next_state == S_ENDOP);
      ack           <= (next_state == S_FINAL);
      err           <= abort;
      bank_rd_en    <= (next_state == S_READ);
      bank_wr_en    <= (next_state == S_WRITE);
      rxdata_wr_en  <= (next_state == S_ENDOP) && !dir_q;
      rx_fifo_rd_en <= (next_state == S_ENDOP) && !dir_q;
      tx_fifo_wr_en <= (next_state == S_ENDOP) &&  dir_q;
    end
  end

`ifdef UART_BUS_FSM_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    else if (state == S_FINAL) wait_cnt <= '0;
  end
`endif

  assign present_state_db = state;

endmodule

// File: tb/tb_uart_bus_fsm.sv
// Randomized bench for uart_bus_fsm against a per-access timing model.
module tb_uart_bus_fsm;
  localparam int AW  = 3;
  localparam int TXA = 0;
  localparam int RXA = 1;
  localparam int TMO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rd_en = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          tx_fifo_full = 1'b0, rx_fifo_empty = 1'b0;
  logic          op, ack, err, bank_rd_en, bank_wr_en;
  logic          rxdata_wr_en, tx_fifo_wr_en, rx_fifo_rd_en;
  logic [2:0]    present_state_db;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  uart_bus_fsm #(
    .ADDR_WIDTH(AW), .TXDATA_ADDR(TXA), .RXDATA_ADDR(RXA), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .op(op), .ack(ack), .err(err), .bank_rd_en(bank_rd_en), .bank_wr_en(bank_wr_en),
    .rxdata_wr_en(rxdata_wr_en), .tx_fifo_wr_en(tx_fifo_wr_en),
    .rx_fifo_rd_en(rx_fifo_rd_en), .present_state_db(present_state_db)
  );

  always #5 clock = ~clock;

  // {op, ack, err, bank_rd, bank_wr, rxdata_wr, tx_wr, rx_rd}
  wire [7:0] outs = {op, ack, err, bank_rd_en, bank_wr_en,
                     rxdata_wr_en, tx_fifo_wr_en, rx_fifo_rd_en};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge: issues one request, then checks every cycle until the
  // FSM is back in Idle. L = cycles the blocking FIFO flag stays asserted.
  task automatic run_txn(input bit rq_rd, input bit rq_wr, input logic [AW-1:0] a,
                         input int L);
    bit        is_rd, data, abort;
    int        wc, K;
    bit        cond [64];
    logic [7:0] e;
    txn++;
    is_rd = rq_rd;
    data  = is_rd ? (a == AW'(RXA)) : (a == AW'(TXA));
    abort = 1'b0;
    wc    = data ? L : 0;
`ifdef UART_BUS_FSM_TIMEOUT_EN
    if (data && L > TMO) begin
      wc    = TMO;
      abort = 1'b1;
    end
`endif
    K = !data ? 2 : (abort ? 2 + wc : 3 + wc);
    for (int j = 0; j < 64; j++)
      cond[j] = (j < L) ? 1'b1 : (j == L) ? 1'b0 : 1'($urandom_range(0, 1));

    rd_en = rq_rd; wr_en = rq_wr; addr = a;
    tx_fifo_full  = 1'($urandom_range(0, 1));
    rx_fifo_empty = 1'($urandom_range(0, 1));

    for (int k = 1; k <= K; k++) begin
      @(negedge clock);
      if (k == 1)                             e = is_rd ? 8'b1001_0000 : 8'b1000_1000;
      else if (k == K)                        e = {2'b01, abort, 5'b0};
      else if (data && !abort && k == K - 1)  e = is_rd ? 8'b1000_0101 : 8'b1000_0010;
      else                                    e = 8'b1000_0000;
      chk($sformatf("t%0d_c%0d", txn, k), {24'd0, outs}, {24'd0, e});
      // Requests while busy must be ignored.
      rd_en = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 2) == 0);
      addr  = AW'($urandom);
      if (is_rd) begin
        rx_fifo_empty = cond[k-1];
        tx_fifo_full  = 1'($urandom_range(0, 1));
      end else begin
        tx_fifo_full  = cond[k-1];
        rx_fifo_empty = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clock);
    chk($sformatf("t%0d_idle", txn), {21'd0, present_state_db, outs}, 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_outs",  {24'd0, outs}, 32'd0);
    chk("rst_state", {29'd0, present_state_db}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_txn(1'b1, 1'b0, 3'd2, 0);   // status read: ack at N+2
    run_txn(1'b0, 1'b1, 3'd0, 0);   // unblocked TX write
    run_txn(1'b1, 1'b0, 3'd1, 5);   // RX read, 5 wait cycles
    run_txn(1'b0, 1'b1, 3'd0, 10);  // TX stuck full (aborts when timeout built in)
    run_txn(1'b0, 1'b1, 3'd0, TMO); // flag drops on the expiry cycle
    run_txn(1'b1, 1'b1, 3'd1, 0);   // both requests: read wins
    run_txn(1'b0, 1'b1, 3'd3, 0);   // non-data write

    for (int i = 0; i < 40; i++) begin
      bit r, w;
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(r, w, AW'($urandom_range(0, 3)), $urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clock);
        chk("gap", {21'd0, present_state_db, outs}, 32'd0);
      end
    end

    // Reset mid-Wait: everything clears at once, nothing completes later.
    rd_en = 1'b1; wr_en = 1'b0; addr = 3'd1; rx_fifo_empty = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst_wait", {29'd0, present_state_db}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_outs",  {24'd0, outs}, 32'd0);
    chk("async_rst_state", {29'd0, present_state_db}, 32'd0);
    rx_fifo_empty = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("post_rst_%0d", k), {21'd0, present_state_db, outs}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
